// File: rtl/gray_bcd_display_mux.sv
// Gray input -> synchronised binary (LEDs) -> sequential double-dabble BCD ->
// time-multiplexed common-anode 7-segment display with optional leading-zero blanking.
module gray_bcd_display_mux #(
  parameter int WIDTH       = 4,
  parameter int NUM_DIGITS  = 2,
  parameter int REFRESH_DIV = 27000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic                  clk_pi,
  input  logic                  rst_pi,
  input  logic [WIDTH-1:0]      codigo_gray_pi,
  output logic [WIDTH-1:0]      codigo_bin_led_po,
  output logic [NUM_DIGITS-1:0] anodo_po,
  output logic [6:0]            catodo_po,
  output logic                  conv_busy_po
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int     BCD_W   = 4 * NUM_DIGITS;
  localparam int     CNT_W   = $clog2(REFRESH_DIV);
  localparam int     IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int     SH_W    = $clog2(WIDTH);
  localparam longint MAX_BIN = (longint'(1) << WIDTH) - longint'(1);
  localparam longint DEC_CAP = pow10(NUM_DIGITS);

  if (WIDTH < 2) begin : g_chk_width
    $error("gray_bcd_display_mux: WIDTH must be >= 2");
  end
  if (REFRESH_DIV < 2) begin : g_chk_refresh
    $error("gray_bcd_display_mux: REFRESH_DIV must be >= 2");
  end
  if (DEC_CAP <= MAX_BIN) begin : g_chk_digits
    $error("gray_bcd_display_mux: NUM_DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [WIDTH-1:0] sync1_reg, gs_reg, bin_q_reg, bin_next;

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_bin
    assign bin_next[gi] = ^gs_reg[WIDTH-1:gi];
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      sync1_reg <= '0;
      gs_reg    <= '0;
      bin_q_reg <= '0;
    end else begin
      sync1_reg <= codigo_gray_pi;
      gs_reg    <= sync1_reg;
      bin_q_reg <= bin_next;
    end
  end

  assign codigo_bin_led_po = bin_q_reg;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] last_reg, last_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next, bcd_adj;
  logic [BCD_W-1:0] disp_reg, disp_next;
  logic [SH_W-1:0]  sh_cnt_reg, sh_cnt_next;
  logic             pending_reg, pending_next;

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
  end

  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      last_reg    <= '0;
      bcd_reg     <= '0;
      disp_reg    <= '0;
      sh_cnt_reg  <= '0;
      pending_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      last_reg    <= last_next;
      bcd_reg     <= bcd_next;
      disp_reg    <= disp_next;
      sh_cnt_reg  <= sh_cnt_next;
      pending_reg <= pending_next;
    end
  end

  // The snapshot is taken once per conversion, so later input changes only
  // trigger a fresh conversion from IDLE and never corrupt the display.
  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    last_next    = last_reg;
    bcd_next     = bcd_reg;
    disp_next    = disp_reg;
    sh_cnt_next  = sh_cnt_reg;
    pending_next = pending_reg;
    case (state_reg)
      IDLE: begin
        if (pending_reg || (bin_q_reg != last_reg)) begin
          shift_next   = bin_q_reg;
          last_next    = bin_q_reg;
          bcd_next     = '0;
          pending_next = 1'b0;
          sh_cnt_next  = '0;
          state_next   = SHIFT;
        end
      end
      SHIFT: begin
        bcd_next    = {bcd_adj[BCD_W-2:0], shift_reg[WIDTH-1]};
        shift_next  = shift_reg << 1;
        sh_cnt_next = sh_cnt_reg + SH_W'(1);
        if (sh_cnt_reg == SH_W'(WIDTH - 1)) state_next = LOAD;
      end
      LOAD: begin
        disp_next  = bcd_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign conv_busy_po = (state_reg != IDLE);

  logic [CNT_W-1:0]      ref_cnt_reg, ref_cnt_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic                  ref_wrap;
  logic [NUM_DIGITS-1:0] anodo_reg;
  logic [6:0]            catodo_reg, seg_sel;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] blank;

  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = disp_reg[4*gi +: 4];
    if (gi == 0) begin : g_units
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = BLANK_LZ & ~|disp_reg[BCD_W-1:4*gi];
    end
  end

  always_comb begin
    ref_wrap     = (ref_cnt_reg == CNT_W'(REFRESH_DIV - 1));
    ref_cnt_next = ref_wrap ? '0 : ref_cnt_reg + CNT_W'(1);
    idx_next     = idx_reg;
    if (ref_wrap) begin
      idx_next = (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
    end
  end

  assign seg_sel = blank[idx_reg] ? 7'h7F : seg_decode(nib[idx_reg]);

  // Anode and cathode are both registered from the same index, so they switch together.
  always_ff @(posedge clk_pi) begin
    if (rst_pi) begin
      ref_cnt_reg <= '0;
      idx_reg     <= '0;
      anodo_reg   <= '1;
      catodo_reg  <= 7'h7F;
    end else begin
      ref_cnt_reg <= ref_cnt_next;
      idx_reg     <= idx_next;
      anodo_reg   <= ~(NUM_DIGITS'(1) << idx_reg);
      catodo_reg  <= seg_sel;
    end
  end

  assign anodo_po  = anodo_reg;
  assign catodo_po = catodo_reg;

endmodule

// File: tb/tb_gray_bcd_display_mux.sv
// Directed bench: two 4-bit/2-digit instances (blanking on/off) and one 8-bit/3-digit instance.
module tb_gray_bcd_display_mux;
  localparam int RD = 4;

  typedef struct {
    logic [3:0] gray;
    logic [3:0] led;
    logic [6:0] d0;
    logic [6:0] d1;
    int         busy;
  } vec_t;

  vec_t tv [16];

  logic       clk = 1'b0;
  logic       rst4, rst8;
  logic [3:0] gray4;
  logic [7:0] gray8;
  logic [3:0] led_a, led_b;
  logic [1:0] an_a, an_b;
  logic [6:0] cat_a, cat_b, cat_c;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] led_c;
  logic [2:0] an_c;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_bcd_display_mux #(.WIDTH(4), .NUM_DIGITS(2), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut_a (
    .clk_pi(clk), .rst_pi(rst4), .codigo_gray_pi(gray4), .codigo_bin_led_po(led_a),
    .anodo_po(an_a), .catodo_po(cat_a), .conv_busy_po(busy_a));

  gray_bcd_display_mux #(.WIDTH(4), .NUM_DIGITS(2), .REFRESH_DIV(RD), .BLANK_LZ(1'b0)) dut_b (
    .clk_pi(clk), .rst_pi(rst4), .codigo_gray_pi(gray4), .codigo_bin_led_po(led_b),
    .anodo_po(an_b), .catodo_po(cat_b), .conv_busy_po(busy_b));

  gray_bcd_display_mux #(.WIDTH(8), .NUM_DIGITS(3), .REFRESH_DIV(RD), .BLANK_LZ(1'b1)) dut_c (
    .clk_pi(clk), .rst_pi(rst8), .codigo_gray_pi(gray8), .codigo_bin_led_po(led_c),
    .anodo_po(an_c), .catodo_po(cat_c), .conv_busy_po(busy_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input int sel, input logic lvl, input string name);
    int   g;
    logic b;
    g = 0;
    b = (sel == 0) ? busy_a : busy_c;
    while (b !== lvl && g < 60) begin
      tick();
      g++;
      b = (sel == 0) ? busy_a : busy_c;
    end
    check(name, 32'(b), 32'(lvl));
  endtask

  task automatic scan4(output logic [6:0] d0, output logic [6:0] d1, output logic [6:0] d1b,
                       output int n0, output int n1, output int nbad);
    d0 = 'x; d1 = 'x; d1b = 'x;
    n0 = 0; n1 = 0; nbad = 0;
    for (int k = 0; k < 2 * RD; k++) begin
      tick();
      case (an_a)
        2'b10: begin
          if (n0 > 0 && cat_a !== d0) nbad++;
          d0 = cat_a; n0++;
        end
        2'b01: begin
          if (n1 > 0 && cat_a !== d1) nbad++;
          d1 = cat_a; n1++;
        end
        default: nbad++;
      endcase
      if (an_b == 2'b01) d1b = cat_b;
    end
  endtask

  task automatic apply4(input int i, input logic [3:0] prev);
    int         nb, g, n0, n1, nbad;
    logic [6:0] d0, d1, d1b;
    gray4 = tv[i].gray;
    tick(); tick();
    check($sformatf("v%0d_led_hold", i), 32'(led_a), 32'(prev));
    tick();
    check($sformatf("v%0d_led", i), 32'(led_a), 32'(tv[i].led));
    tick();
    nb = 0; g = 0;
    while (busy_a === 1'b1 && g < 40) begin
      nb++; tick(); g++;
    end
    check($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(tv[i].busy));
    tick();
    scan4(d0, d1, d1b, n0, n1, nbad);
    check($sformatf("v%0d_digit0", i), 32'(d0), 32'(tv[i].d0));
    check($sformatf("v%0d_digit1", i), 32'(d1), 32'(tv[i].d1));
    check($sformatf("v%0d_digit1_noblank", i), 32'(d1b),
          32'((tv[i].d1 == 7'h7F) ? 7'h40 : tv[i].d1));
    check($sformatf("v%0d_refresh_counts", i), {n0[15:0], n1[15:0]}, {16'(RD), 16'(RD)});
    check($sformatf("v%0d_anode_glitches", i), 32'(nbad), 32'd0);
    $display("vec %0d gray=%b led=%0d busy=%0d d0=%b d1=%b d1_noblank=%b",
             i, tv[i].gray, led_a, nb, d0, d1, d1b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nbad, g, n0, n1, n2;
    logic [6:0] d0, d1, d1b, d2;
    logic [3:0] prev;

    tv[0]  = '{4'b0000, 4'd0,  7'h40, 7'h7F, 0};
    tv[1]  = '{4'b0001, 4'd1,  7'h79, 7'h7F, 5};
    tv[2]  = '{4'b0011, 4'd2,  7'h24, 7'h7F, 5};
    tv[3]  = '{4'b0010, 4'd3,  7'h30, 7'h7F, 5};
    tv[4]  = '{4'b0110, 4'd4,  7'h19, 7'h7F, 5};
    tv[5]  = '{4'b0111, 4'd5,  7'h12, 7'h7F, 5};
    tv[6]  = '{4'b0101, 4'd6,  7'h02, 7'h7F, 5};
    tv[7]  = '{4'b0100, 4'd7,  7'h78, 7'h7F, 5};
    tv[8]  = '{4'b1100, 4'd8,  7'h00, 7'h7F, 5};
    tv[9]  = '{4'b1101, 4'd9,  7'h10, 7'h7F, 5};
    tv[10] = '{4'b1111, 4'd10, 7'h40, 7'h79, 5};
    tv[11] = '{4'b1110, 4'd11, 7'h79, 7'h79, 5};
    tv[12] = '{4'b1010, 4'd12, 7'h24, 7'h79, 5};
    tv[13] = '{4'b1011, 4'd13, 7'h30, 7'h79, 5};
    tv[14] = '{4'b1001, 4'd14, 7'h19, 7'h79, 5};
    tv[15] = '{4'b1000, 4'd15, 7'h12, 7'h79, 5};

    // Reset held for two edges.
    rst4 = 1'b1; rst8 = 1'b1; gray4 = 4'b0000; gray8 = 8'h00;
    tick(); tick();
    check("t1_anode", 32'(an_a), 32'h3);
    check("t1_cathode", 32'(cat_a), 32'h7F);
    check("t1_led", 32'(led_a), 32'h0);
    check("t1_busy", 32'(busy_a), 32'h0);
    check("t1_anode_w8", 32'(an_c), 32'h7);
    rst4 = 1'b0; rst8 = 1'b0;
    tick();
    check("t1_release_anode", 32'(an_a), 32'h2);
    check("t1_release_cathode", 32'(cat_a), 32'h40);
    check("t1_pending_conv", 32'(busy_a), 32'h1);
    $display("reset: anode=%b cathode=%b busy=%b", an_a, cat_a, busy_a);
    wait_busy(0, 1'b0, "t1_conv_done");
    wait_busy(1, 1'b0, "t1_conv_done_w8");

    prev = 4'd0;
    for (int i = 0; i < 16; i++) begin
      apply4(i, prev);
      prev = tv[i].led;
    end

    // Input change two cycles into SHIFT: old snapshot finishes, then a restart.
    gray4 = 4'b0001;
    wait_busy(0, 1'b1, "t5_start");
    tick(); tick();
    gray4 = 4'b1111;
    wait_busy(0, 1'b0, "t5_first_done");
    tick();
    check("t5_second_pulse", 32'(busy_a), 32'h1);
    nbad = 0; g = 0;
    while (busy_a === 1'b1 && g < 40) begin
      if (an_a == 2'b10 && cat_a !== 7'h79) nbad++;
      if (an_a == 2'b01 && cat_a !== 7'h7F) nbad++;
      tick(); g++;
    end
    check("t5_shows_one_meanwhile", 32'(nbad), 32'd0);
    check("t5_second_done", 32'(busy_a), 32'h0);
    tick();
    scan4(d0, d1, d1b, n0, n1, nbad);
    check("t5_led", 32'(led_a), 32'd10);
    check("t5_digit0", 32'(d0), 32'h40);
    check("t5_digit1", 32'(d1), 32'h79);
    $display("t5: led=%0d d0=%b d1=%b", led_a, d0, d1);

    // Wide instance: 255 shown as 2,5,5.
    gray8 = 8'h80;
    tick(); tick();
    check("t6_led_hold", 32'(led_c), 32'h0);
    tick();
    check("t6_led", 32'(led_c), 32'hFF);
    tick();
    n0 = 0; g = 0;
    while (busy_c === 1'b1 && g < 40) begin
      n0++; tick(); g++;
    end
    check("t6_busy_cycles", 32'(n0), 32'd9);
    tick();
    d0 = 'x; d1 = 'x; d2 = 'x; n0 = 0; n1 = 0; n2 = 0; nbad = 0;
    for (int k = 0; k < 3 * RD; k++) begin
      tick();
      case (an_c)
        3'b110:  begin d0 = cat_c; n0++; end
        3'b101:  begin d1 = cat_c; n1++; end
        3'b011:  begin d2 = cat_c; n2++; end
        default: nbad++;
      endcase
    end
    check("t6_digit0", 32'(d0), 32'h12);
    check("t6_digit1", 32'(d1), 32'h12);
    check("t6_digit2", 32'(d2), 32'h24);
    check("t6_refresh_counts", {n0[7:0], n1[7:0], n2[7:0], nbad[7:0]},
          {8'(RD), 8'(RD), 8'(RD), 8'd0});
    $display("t6: led=%0h d0=%b d1=%b d2=%b", led_c, d0, d1, d2);

    // Reset in the middle of SHIFT.
    gray8 = 8'h01;
    wait_busy(1, 1'b1, "t6_second_start");
    tick(); tick();
    rst8 = 1'b1;
    tick();
    check("t6_rst_anode", 32'(an_c), 32'h7);
    check("t6_rst_cathode", 32'(cat_c), 32'h7F);
    check("t6_rst_led", 32'(led_c), 32'h0);
    check("t6_rst_busy", 32'(busy_c), 32'h0);
    rst8 = 1'b0;
    tick();
    check("t6_release_anode", 32'(an_c), 32'h6);
    check("t6_release_cathode", 32'(cat_c), 32'h40);
    check("t6_release_busy", 32'(busy_c), 32'h1);
    $display("t6 reset: anode=%b cathode=%b busy=%b", an_c, cat_c, busy_c);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
